// File: rtl/quant_sched.sv
// quant_sched: per-layer scheduler for the INT32->INT8 requantizer.
// It accepts channel-interleaved accumulator beats and looks up per-channel (M, n, relu).
// It issues each beat to the external 4-stage requantizer with stage-aligned parameters.
// It limits issue with credits so that every returned byte fits in the result FIFO.
// It packs returned INT8 bytes into PACK-lane words.
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_*                      parameter table write (IDLE only)
//   layer_start/channels       start a layer with the given channel count
//   acc_*                      accumulator input stream (valid/ready, last)
//   q_*                        requantizer drive (data/valid/M/n/relu) and result return
//   out_*                      packed INT8 word stream (valid/ready, last)
//   busy, cfg_err              status; cfg_err is sticky until the next layer_start
module quant_sched #(
  parameter int unsigned NUM_CH     = 64,
  parameter int unsigned PACK       = 8,
  parameter int unsigned QLAT       = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [31:0]               cfg_M,
  input  logic [4:0]                cfg_n,
  input  logic                      cfg_relu,
  input  logic                      layer_start,
  input  logic [$clog2(NUM_CH):0]   layer_channels,
  input  logic [31:0]               acc_data,
  input  logic                      acc_valid,
  input  logic                      acc_last,
  output logic                      acc_ready,
  output logic [31:0]               q_data_in,
  output logic                      q_valid_in,
  output logic [31:0]               q_M,
  output logic [4:0]                q_n,
  output logic                      q_use_relu,
  input  logic [7:0]                q_data_out,
  input  logic                      q_valid_out,
  output logic [8*PACK-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      cfg_err
);

  localparam int unsigned AW = $clog2(NUM_CH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  // Parameter table: deliberately not reset, software rewrites it before each use.
  logic [31:0] tab_m    [NUM_CH];
  logic [4:0]  tab_n    [NUM_CH];
  logic        tab_relu [NUM_CH];

  logic [AW:0]        ch_num_q;
  logic [AW-1:0]      ch_cnt_q;
  logic               cfg_err_q;
  logic [CW-1:0]      inflight_q, fifo_cnt_q;
  logic [CW:0]        credits;
  logic               accept, push, pop, fire, push_last;

  // Issue pipeline and per-stage parameter delay lines.
  logic [31:0]        q_data_q, m_d1_q, q_m_q;
  logic               q_valid_q, last_iss_q;
  logic [4:0]         n_d1_q, n_d2_q, q_n_q;
  logic [QLAT-1:0]    last_pipe_q;

  // Result FIFO: {byte, last_flag}.
  logic [8:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [8:0]         head;

  // Packer.
  logic [8*PACK-1:0]  pk_data_q, pk_data_d;
  logic [LW-1:0]      pk_cnt_q, pk_cnt_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;

  // inflight counts beats from acceptance (not issue) until return, so the beat
  // sitting in the issue register already holds a FIFO slot.
  assign credits   = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign acc_ready = (state_q == StRun) && (credits < (CW+1)'(FIFO_DEPTH));
  assign accept    = acc_valid & acc_ready;
  assign push      = q_valid_out;
  assign push_last = last_pipe_q[QLAT-1];
  assign fire      = out_valid_q & out_ready;
  assign head      = fifo_mem[rd_ptr_q];
  assign pop       = (fifo_cnt_q != '0) && (!out_valid_q || out_ready);

  // relu feeds stage 1 one cycle ahead of the data, i.e. in the accept cycle.
  assign q_use_relu = accept & tab_relu[ch_cnt_q];
  assign q_data_in  = q_data_q;
  assign q_valid_in = q_valid_q;
  assign q_M        = q_m_q;
  assign q_n        = q_n_q;
  assign out_data   = out_valid_q ? pk_data_q : '0;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != StIdle);
  assign cfg_err    = cfg_err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == StIdle && cfg_we) begin
      tab_m[cfg_addr]    <= cfg_M;
      tab_n[cfg_addr]    <= cfg_n;
      tab_relu[cfg_addr] <= cfg_relu;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (layer_start) state_d = StRun;
      StRun:   if (accept && acc_last) state_d = StDrain;
      StDrain: if (fire && out_last_q && inflight_q == '0 && fifo_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ch_num_q   <= '0;
      ch_cnt_q   <= '0;
      cfg_err_q  <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (layer_start) begin
          ch_num_q  <= layer_channels;
          ch_cnt_q  <= '0;
          cfg_err_q <= 1'b0;
        end
      end else if (cfg_we || layer_start) begin
        cfg_err_q <= 1'b1;
      end
      if (accept) begin
        ch_cnt_q <= ({1'b0, ch_cnt_q} == ch_num_q - 1'b1) ? '0 : ch_cnt_q + 1'b1;
      end
      case ({accept, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Parameters are captured per issue slot at accept time, then delayed so that
  // M lands in stage 2 (t+1) and n in stage 3 (t+2) of that slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid_q   <= 1'b0;
      q_data_q    <= '0;
      last_iss_q  <= 1'b0;
      m_d1_q      <= '0;
      n_d1_q      <= '0;
      q_m_q       <= '0;
      n_d2_q      <= '0;
      q_n_q       <= '0;
      last_pipe_q <= '0;
    end else begin
      q_valid_q  <= accept;
      last_iss_q <= accept & acc_last;
      if (accept) begin
        q_data_q <= acc_data;
        m_d1_q   <= tab_m[ch_cnt_q];
        n_d1_q   <= tab_n[ch_cnt_q];
      end
      q_m_q       <= q_valid_q ? m_d1_q : '0;
      n_d2_q      <= q_valid_q ? n_d1_q : '0;
      q_n_q       <= n_d2_q;
      last_pipe_q <= {last_pipe_q[QLAT-2:0], q_valid_q & last_iss_q};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {q_data_out, push_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // A word accepted this cycle frees the packer, so the next byte may start a new
  // word in the same cycle.
  always_comb begin
    pk_data_d   = pk_data_q;
    pk_cnt_d    = pk_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (fire) begin
      pk_data_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (pop) begin
      pk_data_d[{pk_cnt_q, 3'b000} +: 8] = head[8:1];
      if (head[0] || pk_cnt_q == LW'(PACK - 1)) begin
        out_valid_d = 1'b1;
        out_last_d  = head[0];
        pk_cnt_d    = '0;
      end else begin
        pk_cnt_d = pk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_data_q   <= '0;
      pk_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      pk_data_q   <= pk_data_d;
      pk_cnt_q    <= pk_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
